ocm_write_scheduler: RTL and testbench
======================================

Name: ocm_write_scheduler

Overview:
Sequences and shares the On-Chip RAM 1 s1 write port between NUM_REQ datapath writers, for example the per-output result writer and the auxiliary-data writer.
Each frame runs three steps in order: a clear pass, a round-robin arbitration window that ends after FRAME_WORDS accepted writes, and a done handshake with the HPS.
The block sits between the pipeline writers and the OCM s1 port; it is the only driver of the OCM write signals.

Parameters:
NUM_REQ, 2, number of write requesters
ADDR_W, 17, OCM word address width
DATA_W, 8, OCM data width
CLEAR_WORDS, 4001, number of words zeroed per clear pass (addresses 0..CLEAR_WORDS-1)
FRAME_WORDS, 160, accepted requester writes per frame (16 pixels x 10 outputs)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE
req  in  NUM_REQ  per-requester write request, held until granted
req_addr  in  NUM_REQ*ADDR_W  packed write addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
gnt  out  NUM_REQ  one-hot, combinational; requester i's write is accepted at this clock edge
ocm1_writedata  out  DATA_W  OCM write data (registered)
ocm1_addr  out  ADDR_W  OCM address (registered)
ocm1_chip  out  1  OCM chipselect
ocm1_clk_enab  out  1  OCM clock enable
ocm1_write  out  1  OCM write strobe, one cycle per word
busy  out  1  high in CLEAR and ARB
clear_active  out  1  high in CLEAR
frame_done  out  1  high in DONE
hps_ack  in  1  HPS acknowledges frame_done
word_count  out  16  requester writes accepted this frame

Behaviour:
- Reset (reset_n=0, asynchronous) forces: state=IDLE, ocm1_write=0, ocm1_clk_enab=0, ocm1_chip=1, ocm1_addr=0, ocm1_writedata=0, word_count=0, round-robin pointer=NUM_REQ-1 (requester 0 has first priority).
- Reset asserted mid-operation aborts the clear or frame at once. No partial write is issued after reset.
- States are IDLE, CLEAR, ARB and DONE.
- IDLE: no writes. start=1 moves to CLEAR, sets clr_addr=0 and word_count=0. start is ignored in every other state.
- CLEAR: each cycle registers ocm1_addr=clr_addr, ocm1_writedata=0, ocm1_write=1, ocm1_clk_enab=1, then clr_addr increments.
  - After address CLEAR_WORDS-1 is issued, go to ARB.
  - gnt stays all-zero in CLEAR; req is held off.
  - The clear pass takes exactly CLEAR_WORDS cycles.
- ARB: gnt is a combinational round-robin choice among asserted req bits.
  - Search starts at pointer+1 and wraps modulo NUM_REQ.
  - At most one grant per cycle. The pointer updates to the granted index on the edge.
  - On a grant edge: ocm1_addr<=req_addr[i], ocm1_writedata<=req_data[i], ocm1_write<=1, word_count<=word_count+1.
  - Latency: a grant in cycle N produces ocm1_write high in cycle N+1.
  - Cycles with no request leave ocm1_write=0.
  - The grant that brings word_count to FRAME_WORDS is the last one: gnt is forced to 0 from the next cycle, and the state moves to DONE on that edge.
- DONE: frame_done=1, no writes, word_count holds its final value. hps_ack=1 returns to IDLE; frame_done drops on the same edge.
- Simultaneous hps_ack and start in DONE: ack is taken, start is ignored (only sampled in IDLE).
- ocm1_clk_enab=1 whenever busy, otherwise 0. ocm1_chip is constant 1.
- word_count saturates at FRAME_WORDS; it never wraps.
- Requester addresses pass through unchanged; the block does no bounds checking.

Decomposition:
- Shared package ocm_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, ARB, DONE);
  - default values for CLEAR_WORDS and FRAME_WORDS;
  - the OCM ADDR_W and DATA_W constants, reused by the writer blocks.
- One sub-module, rr_arbiter (NUM_REQ): inputs req, enable; outputs gnt; holds the registered pointer with an asynchronous active-low reset.

Test Plan:
- Reset, then start pulse -> exactly 4001 consecutive ocm1_write cycles at addresses 0..4000 with data 0; clear_active high for 4001 cycles; gnt=0 throughout.
- ARB with req=2'b11 held continuously -> gnt alternates 01,10,01,...; requester 0 is granted first; each OCM write appears one cycle after its grant with matching addr/data.
- Sparse requests totalling 160 grants -> frame_done rises on the edge after the 160th grant; word_count=160; a 161st request receives no grant.
- Assert reset_n=0 at clear address 2000 -> ocm1_write=0 immediately; after release the block is in IDLE with no writes until the next start.
- start pulses during CLEAR/ARB/DONE -> ignored, no restart; in DONE hps_ack=1 -> IDLE next cycle; a following start begins a fresh clear with word_count=0.
- Single requester req=2'b10 only -> gnt=2'b10 every cycle; 160 writes in 160 consecutive cycles; the pointer does not stall on the idle requester.

Source files
------------

// File: rtl/ocm_ctrl_pkg.sv
// Shared constants and state encoding for the OCM write-side control blocks.
package ocm_ctrl_pkg;

  // OCM port geometry, reused by the datapath writer blocks.
  localparam int unsigned OcmAddrW = 17;
  localparam int unsigned OcmDataW = 8;

  // Frame defaults: words zeroed per clear pass, requester writes per frame (16 px x 10 outputs).
  localparam int unsigned ClearWordsDefault = 4001;
  localparam int unsigned FrameWordsDefault = 160;

  // Scheduler states.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StClear = 2'd1;
  localparam state_t StArb   = 2'd2;
  localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts after the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Pointer resets to the last index so requester 0 wins the first contest.
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_REQ - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Pick the first asserted request at ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned     idx;
    logic [PtrW-1:0] sel;
    logic            found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PtrW'(idx);
      if (enable && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        ptr_d    = sel;
        found    = 1'b1;
      end
    end
  end

  // Remember the last granted index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PtrRst;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ocm_write_scheduler.sv
// Owns the OCM s1 write port: clears the buffer, then shares it round-robin between
// datapath writers for one frame, then hands the frame to the HPS.
module ocm_write_scheduler
  import ocm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = OcmAddrW,
  parameter int unsigned DATA_W      = OcmDataW,
  parameter int unsigned CLEAR_WORDS = ClearWordsDefault,
  parameter int unsigned FRAME_WORDS = FrameWordsDefault
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         ocm1_writedata,
  output logic [ADDR_W-1:0]         ocm1_addr,
  output logic                      ocm1_chip,
  output logic                      ocm1_clk_enab,
  output logic                      ocm1_write,
  output logic                      busy,
  output logic                      clear_active,
  output logic                      frame_done,
  input  logic                      hps_ack,
  output logic [15:0]               word_count
);

  localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(CLEAR_WORDS - 1);
  localparam logic [15:0]       WcLast  = 16'(FRAME_WORDS - 1);
  localparam logic [15:0]       WcFull  = 16'(FRAME_WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [15:0]         wc_q, wc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                arb_en;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Saturation guard: no grant can ever push word_count past FRAME_WORDS.
  assign arb_en = (state_q == StArb) && (wc_q != WcFull);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .enable  (arb_en),
    .gnt     (gnt)
  );

  // AND-OR mux of the granted requester's address and data (gnt is one-hot).
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Frame sequencing and next OCM write.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wc_d       = wc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          clr_addr_d = '0;
          wc_d       = '0;
        end
      end
      StClear: begin
        addr_d     = clr_addr_q;
        wdata_d    = '0;
        write_d    = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ClrLast) state_d = StArb;
      end
      StArb: begin
        if (|gnt) begin
          addr_d  = sel_addr;
          wdata_d = sel_data;
          write_d = 1'b1;
          wc_d    = wc_q + 16'd1;
          if (wc_q == WcLast) state_d = StDone;
        end
      end
      StDone: begin
        if (hps_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered OCM port; reset drops any in-flight write at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      wc_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wc_q       <= wc_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
    end
  end

  assign busy           = (state_q == StClear) || (state_q == StArb);
  assign clear_active   = (state_q == StClear);
  assign frame_done     = (state_q == StDone);
  assign ocm1_clk_enab  = busy;
  assign ocm1_chip      = 1'b1;
  assign ocm1_write     = write_q;
  assign ocm1_addr      = addr_q;
  assign ocm1_writedata = wdata_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_ocm_write_scheduler.sv
// Randomized directed bench for ocm_write_scheduler with a frame-level reference model.
module tb_ocm_write_scheduler;

  localparam int NR = 2;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int CW = 4001;
  localparam int FW = 160;

  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_ARB   = 2;
  localparam int PH_DONE  = 3;

  logic             clk = 1'b0;
  logic             reset_n, start, hps_ack;
  logic [NR-1:0]    req, gnt;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    ocm1_writedata;
  logic [AW-1:0]    ocm1_addr;
  logic             ocm1_chip, ocm1_clk_enab, ocm1_write, busy, clear_active, frame_done;
  logic [15:0]      word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame phase, clear progress, accepted writes, last winner, pending write.
  int            m_ph, m_clr, m_wc, m_last;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Observed tallies.
  int            n_wr, n_clr, n_gnt;
  logic [NR-1:0] last_gnt_obs;

  always #5 clk = ~clk;

  ocm_write_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .gnt            (gnt),
    .ocm1_writedata (ocm1_writedata),
    .ocm1_addr      (ocm1_addr),
    .ocm1_chip      (ocm1_chip),
    .ocm1_clk_enab  (ocm1_clk_enab),
    .ocm1_write     (ocm1_write),
    .busy           (busy),
    .clear_active   (clear_active),
    .frame_done     (frame_done),
    .hps_ack        (hps_ack),
    .word_count     (word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first asserted request after the last winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph   = PH_IDLE;
    m_clr  = 0;
    m_wc   = 0;
    m_last = NR - 1;
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at the posedge.
  task automatic cycle(input logic s, input logic [NR-1:0] r, input logic ack);
    int            g_idx;
    logic [NR-1:0] g_exp;
    logic          busy_e;
    start   = s;
    req     = r;
    hps_ack = ack;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'($urandom);
      req_data[i*DW +: DW] = DW'($urandom);
    end
    @(negedge clk);
    g_idx = (m_ph == PH_ARB) ? rr_pick(r, m_last) : -1;
    g_exp = '0;
    if (g_idx >= 0) g_exp[g_idx] = 1'b1;
    busy_e = (m_ph == PH_CLEAR) || (m_ph == PH_ARB);
    check("cycle_ctl",
          64'({gnt, busy, clear_active, frame_done, ocm1_clk_enab, ocm1_chip, ocm1_write,
               word_count}),
          64'({g_exp, busy_e, m_ph == PH_CLEAR, m_ph == PH_DONE, busy_e, 1'b1, m_wr,
               16'(m_wc)}));
    if (m_wr) check("cycle_wr", 64'({ocm1_addr, ocm1_writedata}), 64'({m_addr, m_data}));
    if (ocm1_write) n_wr++;
    if (clear_active) n_clr++;
    if (|gnt) n_gnt++;
    last_gnt_obs = gnt;
    @(posedge clk);
    m_wr = 1'b0;
    case (m_ph)
      PH_IDLE: if (s) begin
        m_ph  = PH_CLEAR;
        m_clr = 0;
        m_wc  = 0;
      end
      PH_CLEAR: begin
        m_wr   = 1'b1;
        m_addr = AW'(m_clr);
        m_data = '0;
        m_clr++;
        if (m_clr == CW) m_ph = PH_ARB;
      end
      PH_ARB: if (g_idx >= 0) begin
        m_wr   = 1'b1;
        m_addr = req_addr[g_idx*AW +: AW];
        m_data = req_data[g_idx*DW +: DW];
        m_wc++;
        m_last = g_idx;
        if (m_wc == FW) m_ph = PH_DONE;
      end
      PH_DONE: if (ack) m_ph = PH_IDLE;
      default: m_ph = PH_IDLE;
    endcase
    #1;
  endtask

  task automatic clear_pass(input int start_at);
    for (int c = 0; c < CW; c++) cycle(c == start_at, NR'($urandom), 1'b0);
  endtask

  initial begin
    int nc;
    reset_n  = 1'b0;
    start    = 1'b0;
    hps_ack  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    model_reset();

    // Reset values, with requests present.
    #12;
    req = 2'b11;
    #1;
    check("rst_write", 64'(ocm1_write), 64'(0));
    check("rst_clk_enab", 64'(ocm1_clk_enab), 64'(0));
    check("rst_chip", 64'(ocm1_chip), 64'(1));
    check("rst_addr", 64'(ocm1_addr), 64'(0));
    check("rst_data", 64'(ocm1_writedata), 64'(0));
    check("rst_wc", 64'(word_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_gnt", 64'(gnt), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cycle(1'b0, NR'($urandom), 1'b0);

    // Frame 1: clear with stray starts, then both requesters held.
    cycle(1'b1, '0, 1'b0);
    n_clr = 0;
    n_wr  = 0;
    n_gnt = 0;
    for (int c = 0; c < CW; c++) cycle(c == 100 || c == 3000, NR'($urandom), 1'b0);
    cycle(1'b0, 2'b11, 1'b0);
    check("clr_cycles", 64'(n_clr), 64'(CW));
    check("clr_writes", 64'(n_wr), 64'(CW));
    check("clr_gnt_none", 64'(n_gnt), 64'(1));
    check("first_gnt", 64'(last_gnt_obs), 64'(2'b01));
    for (int k = 0; k < 400 && m_ph != PH_DONE; k++) cycle(k == 50, 2'b11, 1'b0);
    check("full_done", 64'(frame_done), 64'(1));
    check("full_wc", 64'(word_count), 64'(FW));
    check("full_gnt_total", 64'(n_gnt), 64'(FW));
    cycle(1'b1, 2'b11, 1'b0);
    cycle(1'b0, 2'b11, 1'b0);
    check("no_gnt_161", 64'(last_gnt_obs), 64'(0));
    cycle(1'b1, 2'b11, 1'b1);
    check("ack_idle_busy", 64'(busy), 64'(0));
    check("ack_idle_done", 64'(frame_done), 64'(0));
    repeat (2) cycle(1'b0, 2'b11, 1'b0);

    // Fresh frame, aborted by reset at clear address 2000.
    cycle(1'b1, '0, 1'b0);
    check("fresh_wc", 64'(word_count), 64'(0));
    for (int c = 0; c < 2001; c++) cycle(1'b0, NR'($urandom), 1'b0);
    check("clr_at_2000", 64'({ocm1_write, ocm1_addr}), 64'({1'b1, AW'(2000)}));
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_write", 64'(ocm1_write), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_wr = 0;
    repeat (6) cycle(1'b0, NR'($urandom), 1'b0);
    check("abort_no_wr", 64'(n_wr), 64'(0));

    // Sparse random requests with stray starts.
    cycle(1'b1, '0, 1'b0);
    clear_pass(-1);
    n_gnt = 0;
    for (int k = 0; k < 3000 && m_ph != PH_DONE; k++) begin
      cycle($urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0, 1'b0);
    end
    check("sparse_done", 64'(frame_done), 64'(1));
    check("sparse_wc", 64'(word_count), 64'(FW));
    check("sparse_gnt_total", 64'(n_gnt), 64'(FW));
    cycle(1'b0, 2'b11, 1'b0);
    check("sparse_no_gnt_161", 64'(last_gnt_obs), 64'(0));
    cycle(1'b0, '0, 1'b1);

    // Single requester 1 only: one write every cycle.
    cycle(1'b1, '0, 1'b0);
    clear_pass(-1);
    n_gnt = 0;
    nc    = 0;
    for (int k = 0; k < 400 && m_ph != PH_DONE; k++) begin
      cycle(1'b0, 2'b10, 1'b0);
      nc++;
    end
    check("single_cycles", 64'(nc), 64'(FW));
    check("single_gnt_total", 64'(n_gnt), 64'(FW));
    check("single_done", 64'(frame_done), 64'(1));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
